// File: rtl/spoofer_pkg.sv
// rtl/spoofer_pkg.sv - shared types and constants for the spoofer AVST source
package spoofer_pkg;

    typedef enum logic [1:0] {
        F_LATCH,
        F_PULSE,
        F_SETTLE,
        F_WAIT
    } fetch_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_SEND,
        O_GAP
    } out_state_t;

    localparam int SETTLE_CYCLES_DEFAULT = 3;
    localparam int PKT_COUNT_W = 16;

endpackage

// File: rtl/spoofer_word_fetch.sv
// rtl/spoofer_word_fetch.sv - pulls counter words into a one-entry buffer
module spoofer_word_fetch
    import spoofer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  take,
    output logic                  word_req,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  full
);

    localparam int SC_W = 8;

    fetch_state_t    state;
    logic [SC_W-1:0] settle_cnt;
    logic            free;

    // A buffer being taken this cycle is already free for the next latch.
    assign free = !full || take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= F_LATCH;
            word       <= '0;
            full       <= 1'b0;
            word_req   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            word_req <= 1'b0;
            if (take) begin
                full <= 1'b0;
            end
            case (state)
                F_LATCH: begin
                    word     <= word_in;
                    full     <= 1'b1;
                    word_req <= 1'b1;
                    state    <= F_PULSE;
                end
                F_PULSE: begin
                    settle_cnt <= '0;
                    if (SETTLE_CYCLES > 1) begin
                        state <= F_SETTLE;
                    end else begin
                        state <= free ? F_LATCH : F_WAIT;
                    end
                end
                F_SETTLE: begin
                    if (settle_cnt == SC_W'(SETTLE_CYCLES - 2)) begin
                        state <= free ? F_LATCH : F_WAIT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                F_WAIT: begin
                    if (free) begin
                        state <= F_LATCH;
                    end
                end
                default: state <= F_LATCH;
            endcase
        end
    end

endmodule

// File: rtl/spoofer_avst_source.sv
// rtl/spoofer_avst_source.sv - frames counter words as Avalon-ST packets
module spoofer_avst_source
    import spoofer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int PKT_LEN       = 256,
    parameter int GAP_CYCLES    = 4,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  word_in,
    output logic                   word_req,
    output logic [DATA_WIDTH-1:0]  src_data,
    output logic                   src_valid,
    input  logic                   src_ready,
    output logic                   src_sop,
    output logic                   src_eop,
    output logic [PKT_COUNT_W-1:0] pkt_count,
    output logic                   busy
);

    localparam int  IDX_W  = $clog2(PKT_LEN) + 1;
    localparam int  GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit  NO_GAP = (GAP_CYCLES == 0);

    out_state_t            state;
    logic [IDX_W-1:0]      beat_idx;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] word;
    logic                  full;
    logic                  take;
    logic                  accept;
    logic                  gap_last;
    logic                  load_sop;
    logic                  load_next;

    spoofer_word_fetch #(
        .DATA_WIDTH    (DATA_WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .word_in  (word_in),
        .take     (take),
        .word_req (word_req),
        .word     (word),
        .full     (full)
    );

    // take is the single point where a buffered word moves into the output register.
    always_comb begin
        accept    = src_valid && src_ready;
        gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
        take      = 1'b0;
        load_sop  = 1'b0;
        case (state)
            O_IDLE: begin
                take     = enable && full;
                load_sop = take;
            end
            O_SEND: begin
                if (accept && src_eop) begin
                    take     = NO_GAP && enable && full;
                    load_sop = take;
                end else if (accept || !src_valid) begin
                    take = full;
                end
            end
            O_GAP: begin
                take     = gap_last && enable && full;
                load_sop = take;
            end
            default: take = 1'b0;
        endcase
        load_next = take && !load_sop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= O_IDLE;
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
            src_data  <= '0;
            beat_idx  <= '0;
            gap_cnt   <= '0;
            pkt_count <= '0;
            busy      <= 1'b0;
        end else begin
            if (take) begin
                src_valid <= 1'b1;
                src_data  <= word;
                src_sop   <= load_sop;
                src_eop   <= load_next && (beat_idx == IDX_W'(PKT_LEN - 1));
                beat_idx  <= load_sop ? IDX_W'(1) : beat_idx + 1'b1;
            end else if (accept) begin
                src_valid <= 1'b0;
            end

            if (accept && src_eop) begin
                pkt_count <= pkt_count + 1'b1;
            end

            case (state)
                O_IDLE: begin
                    if (load_sop) begin
                        state <= O_SEND;
                        busy  <= 1'b1;
                    end
                end
                O_SEND: begin
                    if (accept && src_eop) begin
                        if (NO_GAP) begin
                            state <= load_sop ? O_SEND : O_IDLE;
                            busy  <= load_sop;
                        end else begin
                            state   <= O_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                O_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_last) begin
                        state <= load_sop ? O_SEND : O_IDLE;
                        busy  <= load_sop;
                    end
                end
                default: state <= O_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spoofer_avst_source.sv
// tb/tb_spoofer_avst_source.sv - scoreboard bench for spoofer_avst_source
module tb_spoofer_avst_source;

    localparam int W      = 3;
    localparam int PKT_LEN = 6;
    localparam int GAP    = 2;
    localparam int SETTLE = 3;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         src_ready = 1'b0;
    logic [W-1:0] word_in;
    logic         word_req;
    logic [W-1:0] src_data;
    logic         src_valid;
    logic         src_sop;
    logic         src_eop;
    logic [15:0]  pkt_count;
    logic         busy;

    always #5 clk = ~clk;

    spoofer_avst_source #(
        .DATA_WIDTH    (W),
        .PKT_LEN       (PKT_LEN),
        .GAP_CYCLES    (GAP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .word_in   (word_in),
        .word_req  (word_req),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    // Environment: the upstream counter advances once per rising edge of its read strobe.
    logic [W-1:0] cnt;
    logic         rd_prev;
    always @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rd_prev <= 1'b0;
        end else begin
            rd_prev <= word_req;
            if (word_req && !rd_prev) cnt <= cnt + 1'b1;
        end
    end
    assign word_in = cnt;

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    bit    tp_check = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: the n-th beat since reset carries n mod 2^W, framed every PKT_LEN beats.
    function automatic beat_t model_beat(input int n);
        beat_t b;
        b.data = W'(n % (1 << W));
        b.sop  = (n % PKT_LEN) == 0;
        b.eop  = (n % PKT_LEN) == PKT_LEN - 1;
        return b;
    endfunction

    logic  prev_valid, prev_acc, prev_wr, en_prev, pkt_chk;
    beat_t prev_beat, cur, e;
    int    pulses, accepted, exp_pkts, gap_mon, last_acc_cyc;
    int    cyc = 0;

    always @(negedge clk) begin
        cyc++;
        cur = {src_data, src_sop, src_eop};
        if (rst) begin
            prev_valid   = 1'b0;
            prev_acc     = 1'b0;
            prev_wr      = 1'b0;
            pkt_chk      = 1'b0;
            pulses       = 0;
            accepted     = 0;
            exp_pkts     = 0;
            gap_mon      = GAP;
            last_acc_cyc = -1;
        end else begin
            if (pkt_chk) begin
                check("pkt_count", 64'(pkt_count), 64'(exp_pkts[15:0]));
                pkt_chk = 1'b0;
            end
            if (word_req) begin
                pulses++;
                check("word_req_single", 64'(prev_wr), 64'(0));
                check("word_req_ahead", 64'((pulses - accepted) <= 2), 64'(1));
            end
            if (src_valid) begin
                if (prev_valid && !prev_acc) begin
                    check("hold_stable", 64'(cur), 64'(prev_beat));
                end else if (src_sop) begin
                    check("sop_enable", 64'(en_prev), 64'(1));
                    check("gap_len", 64'(gap_mon >= GAP), 64'(1));
                end
            end else begin
                gap_mon++;
            end
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    check("queue_underrun", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
                if (tp_check && !src_sop && last_acc_cyc >= 0)
                    check("throughput", 64'(cyc - last_acc_cyc), 64'(SETTLE + 1));
                last_acc_cyc = cyc;
                accepted++;
                if (src_eop) begin
                    exp_pkts++;
                    pkt_chk = 1'b1;
                    gap_mon = 0;
                end
            end
            prev_valid = src_valid;
            prev_acc   = src_valid && src_ready;
            prev_beat  = cur;
            prev_wr    = word_req;
            en_prev    = enable;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 1000; i++) exp_q.push_back(model_beat(i));
        @(posedge clk); #1;
        check("rst_valid", 64'(src_valid), 64'(0));
        check("rst_sop", 64'(src_sop), 64'(0));
        check("rst_eop", 64'(src_eop), 64'(0));
        check("rst_data", 64'(src_data), 64'(0));
        check("rst_word_req", 64'(word_req), 64'(0));
        check("rst_pkt_count", 64'(pkt_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("valid_1_after_rst", 64'(src_valid), 64'(0));
        @(posedge clk); #1;
        check("valid_2_after_rst", 64'(src_valid), 64'(1));
        check("first_sop", 64'(src_sop), 64'(1));
        check("first_data", 64'(src_data), 64'(0));
    endtask

    task automatic wait_mid();
        bit found = 1'b0;
        src_ready = 1'b1;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk); #1;
            if (src_valid && !src_sop && !src_eop) found = 1'b1;
        end
        if (!found) check("wait_mid_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        enable    = 1'b1;
        src_ready = 1'b1;
        tp_check  = 1'b1;
        do_reset();
        repeat (80) @(posedge clk);
        #1;
        tp_check = 1'b0;

        // Backpressure on a mid-packet beat.
        wait_mid();
        src_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("stall_valid", 64'(src_valid), 64'(1));
        src_ready = 1'b1;

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            src_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
        end

        // Enable dropped mid-packet: the packet completes, nothing new starts.
        enable = 1'b1;
        wait_mid();
        enable = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("disabled_valid", 64'(src_valid), 64'(0));
        check("disabled_busy", 64'(busy), 64'(0));
        check("disabled_pkts", 64'(pkt_count), 64'(exp_pkts[15:0]));
        enable = 1'b1;

        // Reset mid-packet.
        wait_mid();
        do_reset();

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            src_ready = ($urandom_range(0, 3) != 0);
        end
        src_ready = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("progress", 64'(accepted > 20), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
